// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two per-requester skid FIFOs (ALU, memory) drained round-robin
// onto a single registered broadcast bus. Flush discards everything pending.
module cdb_arbiter #(
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alu_valid,
    input  logic [TAG_W-1:0]             alu_num,
    input  logic [DATA_W-1:0]            alu_value,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [TAG_W-1:0]             mem_num,
    input  logic [DATA_W-1:0]            mem_value,
    output logic                         mem_ready,
    output logic [TAG_W-1:0]             cdb_num,
    output logic [DATA_W-1:0]            cdb_value,
    output logic                         cdb_src,
    output logic [$clog2(DEPTH+1)-1:0]   alu_pending,
    output logic [$clog2(DEPTH+1)-1:0]   mem_pending
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Index 0 = ALU, index 1 = memory unit; matches the cdb_src encoding.
    logic [TAG_W-1:0]  num_mem_q [2][DEPTH];
    logic [DATA_W-1:0] val_mem_q [2][DEPTH];
    logic [PtrW-1:0]   wr_ptr_q  [2];
    logic [PtrW-1:0]   rd_ptr_q  [2];
    logic [CntW-1:0]   cnt_q     [2];
    logic [CntW-1:0]   cnt_d     [2];

    logic              last_grant_q;
    logic [TAG_W-1:0]  cdb_num_q;
    logic [DATA_W-1:0] cdb_value_q;
    logic              cdb_src_q;

    logic              in_valid [2];
    logic [TAG_W-1:0]  in_num   [2];
    logic [DATA_W-1:0] in_value [2];
    logic [1:0]        ready;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        nonempty;
    logic              grant;
    logic              grant_sel;
    logic [TAG_W-1:0]  head_num;
    logic [DATA_W-1:0] head_value;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        in_valid[0] = alu_valid;
        in_num[0]   = alu_num;
        in_value[0] = alu_value;
        in_valid[1] = mem_valid;
        in_num[1]   = mem_num;
        in_value[1] = mem_value;
    end

    always_comb begin
        ready    = '0;
        push     = '0;
        nonempty = '0;
        for (int r = 0; r < 2; r++) begin
            // Ready looks only at the registered count; a same-cycle pop never frees a slot.
            ready[r]    = cnt_q[r] < CntW'(DEPTH);
            push[r]     = in_valid[r] && ready[r] && (in_num[r] != '0) && !flush;
            nonempty[r] = cnt_q[r] != '0;
        end
        grant     = nonempty[0] || nonempty[1];
        grant_sel = (nonempty[0] && nonempty[1]) ? ~last_grant_q : nonempty[1];
        pop[0]    = grant && !grant_sel;
        pop[1]    = grant && grant_sel;
        for (int r = 0; r < 2; r++) begin
            cnt_d[r] = cnt_q[r] + CntW'(push[r]) - CntW'(pop[r]);
        end
        head_num   = num_mem_q[grant_sel][rd_ptr_q[grant_sel]];
        head_value = val_mem_q[grant_sel][rd_ptr_q[grant_sel]];
    end

    // Storage needs no reset: occupancy is tracked by the counters alone.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                num_mem_q[r][wr_ptr_q[r]] <= in_num[r];
                val_mem_q[r][wr_ptr_q[r]] <= in_value[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                cnt_q[r]    <= '0;
            end
            last_grant_q <= 1'b1;
            cdb_num_q    <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < 2; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                cnt_q[r]    <= '0;
            end
            cdb_num_q <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push[r]) wr_ptr_q[r] <= ptr_inc(wr_ptr_q[r]);
                if (pop[r])  rd_ptr_q[r] <= ptr_inc(rd_ptr_q[r]);
                cnt_q[r] <= cnt_d[r];
            end
            if (grant) begin
                last_grant_q <= grant_sel;
                cdb_num_q    <= head_num;
                cdb_value_q  <= head_value;
                cdb_src_q    <= grant_sel;
            end else begin
                cdb_num_q <= '0;
            end
        end
    end

    assign alu_ready   = ready[0];
    assign mem_ready   = ready[1];
    assign alu_pending = cnt_q[0];
    assign mem_pending = cnt_q[1];
    assign cdb_num     = cdb_num_q;
    assign cdb_value   = cdb_value_q;
    assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_cdb_arbiter;

    localparam int unsigned TAG_W  = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CntW   = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              flush;
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_num;
    logic [DATA_W-1:0] alu_value;
    logic              alu_ready;
    logic              mem_valid;
    logic [TAG_W-1:0]  mem_num;
    logic [DATA_W-1:0] mem_value;
    logic              mem_ready;
    logic [TAG_W-1:0]  cdb_num;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_src;
    logic [CntW-1:0]   alu_pending;
    logic [CntW-1:0]   mem_pending;

    cdb_arbiter #(
        .TAG_W (TAG_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alu_valid  (alu_valid),
        .alu_num    (alu_num),
        .alu_value  (alu_value),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_num    (mem_num),
        .mem_value  (mem_value),
        .mem_ready  (mem_ready),
        .cdb_num    (cdb_num),
        .cdb_value  (cdb_value),
        .cdb_src    (cdb_src),
        .alu_pending(alu_pending),
        .mem_pending(mem_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per requester, entries packed as {tag, value}.
    logic [TAG_W+DATA_W-1:0] aq[$];
    logic [TAG_W+DATA_W-1:0] mq[$];
    logic                    m_last = 1'b1;
    logic [TAG_W-1:0]        m_num  = '0;
    logic [DATA_W-1:0]       m_val  = '0;
    logic                    m_src  = 1'b0;
    bit                      live   = 1'b0;

    always @(posedge clk) begin
        logic [TAG_W+DATA_W-1:0] e;
        logic pa, pm, win;
        if (rst) begin
            aq.delete();
            mq.delete();
            m_last = 1'b1;
            m_num  = '0;
            m_val  = '0;
            m_src  = 1'b0;
            live   = 1'b1;
        end else if (flush) begin
            aq.delete();
            mq.delete();
            m_num = '0;
        end else begin
            pa = alu_valid && (aq.size() < DEPTH) && (alu_num != 0);
            pm = mem_valid && (mq.size() < DEPTH) && (mem_num != 0);
            if (aq.size() > 0 || mq.size() > 0) begin
                if (aq.size() > 0 && mq.size() > 0) win = !m_last;
                else                                win = (mq.size() > 0);
                m_last = win;
                if (win) e = mq.pop_front();
                else     e = aq.pop_front();
                m_src = win;
                m_num = e[TAG_W+DATA_W-1:DATA_W];
                m_val = e[DATA_W-1:0];
            end else begin
                m_num = '0;
            end
            if (pa) aq.push_back({alu_num, alu_value});
            if (pm) mq.push_back({mem_num, mem_value});
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("model cdb_num", 64'(cdb_num), 64'(m_num));
            chk("model cdb_value", 64'(cdb_value), 64'(m_val));
            chk("model cdb_src", 64'(cdb_src), 64'(m_src));
            chk("model alu_pending", 64'(alu_pending), 64'(aq.size()));
            chk("model mem_pending", 64'(mem_pending), 64'(mq.size()));
            chk("model alu_ready", 64'(alu_ready), 64'(aq.size() < DEPTH));
            chk("model mem_ready", 64'(mem_ready), 64'(mq.size() < DEPTH));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        flush     = 1'b0;
        alu_valid = 1'b0;
        alu_num   = '0;
        alu_value = '0;
        mem_valid = 1'b0;
        mem_num   = '0;
        mem_value = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic alu_put(input logic [TAG_W-1:0] n, input logic [DATA_W-1:0] v);
        alu_valid = 1'b1;
        alu_num   = n;
        alu_value = v;
    endtask

    task automatic mem_put(input logic [TAG_W-1:0] n, input logic [DATA_W-1:0] v);
        mem_valid = 1'b1;
        mem_num   = n;
        mem_value = v;
    endtask

    initial begin
        logic [TAG_W-1:0] order[$];
        logic [TAG_W-1:0] exp_order[6];
        logic [TAG_W-1:0] atags[3];
        logic [TAG_W-1:0] mtags[3];
        int ai, mi, acc, bc, seen7;
        bit a_acc, m_acc;

        rst = 1'b1;
        idle();
        cyc();
        cyc();
        chk("reset cdb_num", 64'(cdb_num), 0);
        chk("reset cdb_value", 64'(cdb_value), 0);
        chk("reset alu_ready", 64'(alu_ready), 1);
        chk("reset mem_ready", 64'(mem_ready), 1);
        rst = 1'b0;

        // Single ALU result: broadcast one edge after the push, then idle.
        alu_put(3, 32'h11);
        cyc();
        idle();
        chk("t1 pending after push", 64'(alu_pending), 1);
        chk("t1 no bypass", 64'(cdb_num), 0);
        cyc();
        chk("t1 cdb_num", 64'(cdb_num), 3);
        chk("t1 cdb_value", 64'(cdb_value), 32'h11);
        chk("t1 cdb_src", 64'(cdb_src), 0);
        chk("t1 alu_pending", 64'(alu_pending), 0);
        cyc();
        chk("t1 idle", 64'(cdb_num), 0);

        // Simultaneous first contention after reset: ALU wins.
        do_reset();
        alu_put(2, 32'hA);
        mem_put(5, 32'hB);
        cyc();
        idle();
        cyc();
        chk("t2 first num", 64'(cdb_num), 2);
        chk("t2 first src", 64'(cdb_src), 0);
        cyc();
        chk("t2 second num", 64'(cdb_num), 5);
        chk("t2 second value", 64'(cdb_value), 32'hB);
        chk("t2 second src", 64'(cdb_src), 1);
        cyc();
        chk("t2 idle", 64'(cdb_num), 0);

        // Sustained contention: strict alternation.
        do_reset();
        atags = '{3'd1, 3'd2, 3'd3};
        mtags = '{3'd4, 3'd5, 3'd6};
        exp_order = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd3, 3'd6};
        ai = 0;
        mi = 0;
        for (int c = 0; c < 10; c++) begin
            if (ai < 3) alu_put(atags[ai], 32'h100 + 32'(ai));
            else begin alu_valid = 1'b0; alu_num = '0; end
            if (mi < 3) mem_put(mtags[mi], 32'h200 + 32'(mi));
            else begin mem_valid = 1'b0; mem_num = '0; end
            a_acc = alu_valid && alu_ready;
            m_acc = mem_valid && mem_ready;
            cyc();
            if (a_acc) ai++;
            if (m_acc) mi++;
            if (cdb_num != 0) order.push_back(cdb_num);
        end
        idle();
        chk("t3 broadcast count", 64'(order.size()), 6);
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            chk("t3 order", 64'(order[i]), 64'(exp_order[i]));
        end

        // Random backpressure: ALU offers every cycle; nothing lost or duplicated.
        do_reset();
        acc = 0;
        bc  = 0;
        for (int c = 0; c < 1000; c++) begin
            alu_put(3'($urandom_range(1, 7)), $urandom);
            mem_valid = 1'($urandom_range(0, 1));
            mem_num   = 3'($urandom_range(0, 7));
            mem_value = $urandom;
            if (alu_ready) acc++;
            cyc();
            if (cdb_num != 0 && cdb_src == 1'b0) bc++;
        end
        idle();
        chk("t4 alu conservation", 64'(bc + int'(alu_pending)), 64'(acc));

        // Flush with 2 ALU + 1 MEM pending and a concurrent ALU push of tag 7.
        do_reset();
        alu_put(1, 32'h21);
        mem_put(3, 32'h23);
        cyc();
        idle();
        alu_put(2, 32'h22);
        cyc();
        alu_put(4, 32'h24);
        mem_put(5, 32'h25);
        cyc();
        idle();
        chk("t5 alu pending pre", 64'(alu_pending), 2);
        chk("t5 mem pending pre", 64'(mem_pending), 1);
        flush = 1'b1;
        alu_put(7, 32'h77);
        cyc();
        idle();
        chk("t5 cdb idle", 64'(cdb_num), 0);
        chk("t5 alu pending", 64'(alu_pending), 0);
        chk("t5 mem pending", 64'(mem_pending), 0);
        chk("t5 alu ready", 64'(alu_ready), 1);
        seen7 = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if (cdb_num == 7) seen7++;
        end
        chk("t5 tag 7 absent", 64'(seen7), 0);

        // Tag-0 offers are ignored.
        do_reset();
        alu_put(0, 32'hDEAD);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("t6 tag0 pending", 64'(alu_pending), 0);
            chk("t6 tag0 no broadcast", 64'(cdb_num), 0);
        end
        idle();

        // Reset with results pending empties everything like a flush.
        alu_put(1, 32'h31);
        mem_put(2, 32'h32);
        cyc();
        alu_put(3, 32'h33);
        mem_put(4, 32'h34);
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6 rst cdb idle", 64'(cdb_num), 0);
        chk("t6 rst alu pending", 64'(alu_pending), 0);
        chk("t6 rst mem pending", 64'(mem_pending), 0);
        chk("t6 rst mem ready", 64'(mem_ready), 1);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Result-broadcast arbiter between the execution units and the reorder buffer. The ALU and the memory unit each push completed results (ROB tag plus 32-bit value) into a private skid FIFO. Each cycle the block grants one non-empty FIFO round-robin and drives the winner onto a single registered common data bus (CDB). The ROB and reservation stations consume that bus as their one writeback port. A flush from branch/JALR redirect discards every pending result.

## Interface
Parameters:
- TAG_W, 3, ROB tag width; tag 0 means "no result", matching ROB entries 1..7
- DATA_W, 32, result value width
- DEPTH, 2, entries per requester FIFO; legal 1..8

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  drop all pending and in-flight results this edge
- alu_valid  input  1  ALU result offered
- alu_num  input  TAG_W  ROB tag of ALU result
- alu_value  input  DATA_W  ALU result value
- alu_ready  output  1  ALU FIFO can accept
- mem_valid  input  1  memory-unit result offered
- mem_num  input  TAG_W  ROB tag of load result
- mem_value  input  DATA_W  load result value
- mem_ready  output  1  memory FIFO can accept
- cdb_num  output  TAG_W  broadcast tag; 0 = bus idle
- cdb_value  output  DATA_W  broadcast value
- cdb_src  output  1  0 = ALU, 1 = memory
- alu_pending  output  $clog2(DEPTH+1)  ALU FIFO occupancy
- mem_pending  output  $clog2(DEPTH+1)  memory FIFO occupancy

## Operation
- Handshake: a push happens when x_valid && x_ready && x_num != 0 && !flush. A tag-0 offer is ignored and consumes no slot.
- x_ready = (x_pending < DEPTH), computed from the registered count only. A pop in the same cycle does not raise ready.
- FIFOs are circular with wr/rd pointers wrapping at DEPTH. Ordering within one requester is strict FIFO.
- Arbiter state: last_grant (1 bit, reset 1 = memory, so ALU wins the first contention).
  - Only one FIFO non-empty (count at start of cycle): grant it.
  - Both FIFOs non-empty: grant the one not equal to last_grant.
  - On every grant, update last_grant to the winner.
- Grant action: pop the head, register {num, value, src} onto the cdb_* outputs.
- No grant: cdb_num <= 0. cdb_value and cdb_src hold their previous values.
- Push and pop on the same FIFO in the same edge: count unchanged, both pointers advance.
- flush, same edge:
  - Clear both FIFOs (pointers and counts to 0).
  - cdb_num <= 0.
  - Ignore any push presented that cycle.
  - last_grant is unchanged.
- rst dominates flush.

## Timing
- Reset values:
  - cdb_num = 0, cdb_value = 0, cdb_src = 0
  - alu_pending = 0, mem_pending = 0
  - alu_ready = 1, mem_ready = 1
  - last_grant = 1
  - FIFO pointers = 0
- Minimum latency: a result pushed at edge N is eligible at edge N+1 and is driven on the CDB from N+1 to N+2. There is no combinational bypass.
- Each cdb_num != 0 is valid for exactly one cycle. Consumers sample it at the next posedge.
- Throughput: one broadcast per cycle total. Under sustained contention each requester gets 1 grant every 2 cycles.
- Full boundary: with count = DEPTH, ready = 0 that cycle even if a pop occurs. Ready returns the cycle after the pop.
- Empty boundary: the CDB idles (tag 0) the cycle after both counts reach 0.
- Reset or flush mid-stream: the cycle after the edge shows an idle CDB, empty FIFOs and ready = 1.

## Test plan
1. Reset, then ALU pushes (num=3, value=0x11) at edge 1 -> edge 2: cdb_num=3, cdb_value=0x11, cdb_src=0. Edge 3: cdb_num=0, alu_pending=0.
2. ALU (num=2, 0xA) and MEM (num=5, 0xB) pushed on the same edge after reset -> ALU broadcast first, MEM next cycle, then idle.
3. Sustained contention: ALU tags 1,2,3 and MEM tags 4,5,6, both valid every cycle -> CDB order 1,4,2,5,3,6. Neither pending count exceeds DEPTH. Ready deasserts when a count hits 2.
4. DEPTH=2 backpressure: hold MEM behind a full ALU FIFO by offering ALU every cycle -> alu_ready=0 exactly while alu_pending=2. No ALU result is lost or duplicated, checked by scoreboard over 1000 random cycles.
5. Flush with 2 ALU and 1 MEM results pending plus a concurrent ALU push (num=7) -> next cycle cdb_num=0, both pending=0, and tag 7 never appears on the CDB.
6. Tag-0 offer (alu_valid=1, alu_num=0) -> alu_pending stays 0 and no broadcast occurs. Reset asserted with results pending gives the same empty state as a flush.
